seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_pkg.sv | 53 +++++
 rtl/seg7_to_bcd.sv | 34 +++
 rtl/seg_scan_decoder.sv | 118 +++++++++++
 tb/tb_seg_scan_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan decoder.
package seg_scan_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned SEL_W      = 4;
   localparam int unsigned BCD_W      = 4;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned FRAME_W    = NUM_DIGITS * BCD_W;

   // Active-low segment patterns, bit6=g .. bit0=a
   localparam logic [SEG_W-1:0] SEG_PAT_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_PAT_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_PAT_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_PAT_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_PAT_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_PAT_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_PAT_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_PAT_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_PAT_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_PAT_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_PAT_BLANK = 7'b1111111;

   // Active-low one-hot digit selects
   localparam logic [SEL_W-1:0] SEL_D0 = 4'b1110;
   localparam logic [SEL_W-1:0] SEL_D1 = 4'b1101;
   localparam logic [SEL_W-1:0] SEL_D2 = 4'b1011;
   localparam logic [SEL_W-1:0] SEL_D3 = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [SEG_W-1:0] seg;
   } scan_word_t;

   function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
      return sel inside {SEL_D0, SEL_D1, SEL_D2, SEL_D3};
   endfunction

   function automatic logic [1:0] sel_index(input logic [SEL_W-1:0] sel);
      case (sel)
         SEL_D1:  return 2'd1;
         SEL_D2:  return 2'd2;
         SEL_D3:  return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder.
// SEG_DECODE_BLANK_EN: decode the all-off pattern as a legal 0 (leading-zero blanking).
module seg7_to_bcd
   import seg_scan_pkg::*;
(
   input  logic [SEG_W-1:0] pattern,
   output logic [BCD_W-1:0] bcd_c,
   output logic             illegal_c
);

   always_comb begin
      bcd_c     = 4'hF;
      illegal_c = 1'b1;
      case (pattern)
         SEG_PAT_0: begin bcd_c = 4'd0; illegal_c = 1'b0; end
         SEG_PAT_1: begin bcd_c = 4'd1; illegal_c = 1'b0; end
         SEG_PAT_2: begin bcd_c = 4'd2; illegal_c = 1'b0; end
         SEG_PAT_3: begin bcd_c = 4'd3; illegal_c = 1'b0; end
         SEG_PAT_4: begin bcd_c = 4'd4; illegal_c = 1'b0; end
         SEG_PAT_5: begin bcd_c = 4'd5; illegal_c = 1'b0; end
         SEG_PAT_6: begin bcd_c = 4'd6; illegal_c = 1'b0; end
         SEG_PAT_7: begin bcd_c = 4'd7; illegal_c = 1'b0; end
         SEG_PAT_8: begin bcd_c = 4'd8; illegal_c = 1'b0; end
         SEG_PAT_9: begin bcd_c = 4'd9; illegal_c = 1'b0; end
`ifdef SEG_DECODE_BLANK_EN
         SEG_PAT_BLANK: begin bcd_c = 4'd0; illegal_c = 1'b0; end
`else
         SEG_PAT_BLANK: begin bcd_c = 4'hF; illegal_c = 1'b1; end
`endif
         default: begin bcd_c = 4'hF; illegal_c = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit BCD frame from a scanned, active-low seven-segment display bus.
// SEG_DECODE_BLANK_EN: treat the all-off pattern as digit 0 instead of illegal.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic                  CLK_50M,
   input  logic                  RSTn,
   input  logic [SEG_W-1:0]      seg_in,
   input  logic [SEL_W-1:0]      sel_in,
   output logic [FRAME_W-1:0]    digits_o,
   output logic [NUM_DIGITS-1:0] digit_err_o,
   output logic                  frame_valid_o
);

   localparam int unsigned    CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   scan_word_t                sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0]          stable_cnt_q;
   scan_state_t               state_q, state_d;
   logic [FRAME_W-1:0]        stage_q;
   logic [NUM_DIGITS-1:0]     stage_err_q, seen_q, seen_d;
   logic                      changed_c, legal_c, capture_c, frame_done_c;
   logic [1:0]                idx_c;
   logic [BCD_W-1:0]          bcd_c;
   logic                      illegal_c;

   assign changed_c    = (sync2_q != prev_q);
   assign legal_c      = sel_legal(sync2_q.sel);
   assign idx_c        = sel_index(sync2_q.sel);
   assign frame_done_c = (seen_q == '1);

   seg7_to_bcd u_dec (
      .pattern   (sync2_q.seg),
      .bcd_c     (bcd_c),
      .illegal_c (illegal_c)
   );

   // Two-flop synchronizer; all-ones reset reads as "no digit selected"
   always_ff @(posedge CLK_50M or negedge RSTn) begin
      if (!RSTn) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= '{sel: sel_in, seg: seg_in};
         sync2_q <= sync1_q;
      end
   end

   // Stability counter on the synced word, saturating at the capture threshold
   always_ff @(posedge CLK_50M or negedge RSTn) begin
      if (!RSTn) begin
         prev_q       <= '1;
         stable_cnt_q <= '0;
      end else begin
         prev_q <= sync2_q;
         if (changed_c)
            stable_cnt_q <= '0;
         else if (stable_cnt_q != CNT_MAX)
            stable_cnt_q <= stable_cnt_q + CNT_W'(1);
      end
   end

   // Capture fires on the edge where the counter reaches the threshold
   always_comb begin
      state_d   = state_q;
      capture_c = 1'b0;
      if (!legal_c) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_SETTLE;
            ST_SETTLE: begin
               if (!changed_c && stable_cnt_q == CNT_MAX - CNT_W'(1)) begin
                  capture_c = 1'b1;
                  state_d   = ST_HELD;
               end
            end
            ST_HELD:   if (changed_c) state_d = ST_SETTLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // A capture landing on the frame-completion edge keeps its seen bit
   always_comb begin
      seen_d = frame_done_c ? '0 : seen_q;
      if (capture_c)
         seen_d = seen_d | (NUM_DIGITS'(1) << idx_c);
   end

   always_ff @(posedge CLK_50M or negedge RSTn) begin
      if (!RSTn) begin
         state_q       <= ST_IDLE;
         seen_q        <= '0;
         stage_q       <= '0;
         stage_err_q   <= '0;
         digits_o      <= '0;
         digit_err_o   <= '0;
         frame_valid_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         seen_q        <= seen_d;
         frame_valid_o <= frame_done_c;
         if (frame_done_c) begin
            digits_o    <= stage_q;
            digit_err_o <= stage_err_q;
         end
         if (capture_c) begin
            stage_q[{idx_c, 2'b00} +: BCD_W] <= bcd_c;
            stage_err_q[idx_c]               <= illegal_c;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: run-length behavioural model checked every cycle plus literal frame checks.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

   localparam int unsigned S = 16;
   localparam logic [3:0] SEL0 = 4'b1110;
   localparam logic [3:0] SEL1 = 4'b1101;
   localparam logic [3:0] SEL2 = 4'b1011;
   localparam logic [3:0] SEL3 = 4'b0111;
   localparam logic [3:0] SELN = 4'b1111;

   logic        CLK_50M = 1'b0;
   logic        RSTn    = 1'b0;
   logic [6:0]  seg_in  = 7'h7F;
   logic [3:0]  sel_in  = 4'hF;
   logic [15:0] digits_o;
   logic [3:0]  digit_err_o;
   logic        frame_valid_o;

   always #10 CLK_50M = ~CLK_50M;

   seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
      .CLK_50M       (CLK_50M),
      .RSTn          (RSTn),
      .seg_in        (seg_in),
      .sel_in        (sel_in),
      .digits_o      (digits_o),
      .digit_err_o   (digit_err_o),
      .frame_valid_o (frame_valid_o)
   );

   logic [6:0] pat_tab [10];
   int  n_cmp  = 0;
   int  n_bad  = 0;
   int  fv_cnt = 0;
   bit  chk_en = 1'b0;

   // Model state: run length of the pin word, staged digits, and expected outputs
   logic [10:0] m_prev;
   int          m_run;
   logic [15:0] m_stage;
   logic [3:0]  m_serr, m_seen;
   logic [15:0] exp_digits;
   logic [3:0]  exp_err;
   logic        exp_fv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void mdec(input logic [6:0] p, output logic [3:0] v, output logic e);
      v = 4'hF;
      e = 1'b1;
      for (int i = 0; i < 10; i++)
         if (pat_tab[i] == p) begin
            v = 4'(i);
            e = 1'b0;
         end
`ifdef SEG_DECODE_BLANK_EN
      if (p == 7'h7F) begin
         v = 4'h0;
         e = 1'b0;
      end
`endif
   endfunction

   // A pin word seen on S+3 consecutive edges is captured on that edge; frame emerges one edge after completion
   always @(posedge CLK_50M or negedge RSTn) begin : model
      logic [10:0] cur;
      int          nrun;
      int          di;
      logic [3:0]  nseen;
      logic [3:0]  onehot;
      logic [3:0]  v;
      logic        e;
      if (!RSTn) begin
         m_prev     <= '1;
         m_run      <= 0;
         m_stage    <= '0;
         m_serr     <= '0;
         m_seen     <= '0;
         exp_digits <= '0;
         exp_err    <= '0;
         exp_fv     <= 1'b0;
      end else begin
         cur  = {sel_in, seg_in};
         nrun = (m_run > 0 && cur == m_prev) ? ((m_run < 10000) ? m_run + 1 : m_run) : 1;
         m_prev <= cur;
         m_run  <= nrun;
         exp_fv <= (m_seen == 4'hF);
         nseen  = (m_seen == 4'hF) ? 4'h0 : m_seen;
         if (m_seen == 4'hF) begin
            exp_digits <= m_stage;
            exp_err    <= m_serr;
         end
         di = -1;
         for (int i = 0; i < 4; i++) begin
            onehot = 4'b0001 << i;
            if (sel_in == ~onehot) di = i;
         end
         if (di >= 0 && nrun == int'(S) + 3) begin
            mdec(seg_in, v, e);
            m_stage[di*4 +: 4] <= v;
            m_serr[di]         <= e;
            nseen[di]          = 1'b1;
         end
         m_seen <= nseen;
      end
   end

   always @(negedge CLK_50M) begin
      if (chk_en) begin
         check("cyc digits_o", 32'(digits_o), 32'(exp_digits));
         check("cyc digit_err_o", 32'(digit_err_o), 32'(exp_err));
         check("cyc frame_valid_o", 32'(frame_valid_o), 32'(exp_fv));
         if (frame_valid_o) fv_cnt++;
      end
   end

   task automatic show(input logic [3:0] s, input logic [6:0] g, input int n);
      sel_in = s;
      seg_in = g;
      repeat (n) @(posedge CLK_50M);
      #1;
   endtask

   task automatic idle(input int n);
      show(SELN, 7'h7F, n);
   endtask

   task automatic expect_frame(input string name, input int cnt, input logic [15:0] d, input logic [3:0] e);
      check({name, " frame count"}, 32'(fv_cnt), 32'(cnt));
      check({name, " digits_o"}, 32'(digits_o), 32'(d));
      check({name, " digit_err_o"}, 32'(digit_err_o), 32'(e));
      check({name, " model digits"}, 32'(exp_digits), 32'(d));
   endtask

   initial begin
      pat_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      repeat (2) @(posedge CLK_50M);
      #1;
      chk_en = 1'b1;
      check("reset digits_o", 32'(digits_o), 32'h0);
      check("reset digit_err_o", 32'(digit_err_o), 32'h0);
      check("reset frame_valid_o", 32'(frame_valid_o), 32'h0);
      RSTn = 1'b1;
      idle(5);

      // Basic frame 3,5,0,7
      show(SEL0, pat_tab[3], 20);
      show(SEL1, pat_tab[5], 20);
      show(SEL2, pat_tab[0], 20);
      show(SEL3, pat_tab[7], 20);
      idle(5);
      expect_frame("basic", 1, 16'h7053, 4'b0000);

      // Illegal pattern on digit1
      show(SEL0, pat_tab[1], 20);
      show(SEL1, 7'b0110110, 20);
      show(SEL2, pat_tab[2], 20);
      show(SEL3, pat_tab[4], 20);
      idle(5);
      expect_frame("illegal", 2, 16'h42F1, 4'b0010);

      // Digit2 held too briefly, then completed later
      show(SEL0, pat_tab[8], 20);
      show(SEL1, pat_tab[9], 20);
      show(SEL2, pat_tab[2], 10);
      show(SEL3, pat_tab[6], 20);
      idle(5);
      expect_frame("short hold", 2, 16'h42F1, 4'b0010);
      show(SEL2, pat_tab[2], 20);
      idle(5);
      expect_frame("late digit2", 3, 16'h6298, 4'b0000);

      // Blank pattern on digit3
      show(SEL0, pat_tab[1], 20);
      show(SEL1, pat_tab[2], 20);
      show(SEL2, pat_tab[3], 20);
      show(SEL3, 7'h7F, 20);
      idle(5);
`ifdef SEG_DECODE_BLANK_EN
      expect_frame("blank", 4, 16'h0321, 4'b0000);
`else
      expect_frame("blank", 4, 16'hF321, 4'b1000);
`endif

      // Reset after three captures
      show(SEL0, pat_tab[5], 20);
      show(SEL1, pat_tab[6], 20);
      show(SEL2, pat_tab[7], 20);
      RSTn   = 1'b0;
      sel_in = SELN;
      seg_in = 7'h7F;
      #5;
      check("async reset digits_o", 32'(digits_o), 32'h0);
      check("async reset digit_err_o", 32'(digit_err_o), 32'h0);
      check("async reset frame_valid_o", 32'(frame_valid_o), 32'h0);
      @(posedge CLK_50M);
      #1;
      RSTn = 1'b1;
      show(SEL3, pat_tab[8], 20);
      idle(5);
      expect_frame("post reset partial", 4, 16'h0000, 4'b0000);
      show(SEL0, pat_tab[5], 20);
      show(SEL1, pat_tab[6], 20);
      show(SEL2, pat_tab[7], 20);
      idle(5);
      expect_frame("post reset frame", 5, 16'h8765, 4'b0000);

      // Two-hot select must never capture
      show(4'b1100, pat_tab[1], 30);
      expect_frame("two-hot", 5, 16'h8765, 4'b0000);
      show(SEL1, pat_tab[1], 20);
      show(SEL2, pat_tab[2], 20);
      show(SEL3, pat_tab[3], 20);
      idle(5);
      expect_frame("no digit0", 5, 16'h8765, 4'b0000);
      show(SEL0, pat_tab[4], 20);
      idle(5);
      expect_frame("digit0 done", 6, 16'h3214, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
